// File: rtl/alu_step_sequencer.sv
`timescale 1ns/1ps
// alu_step_sequencer: Moore control-step sequencer for one Mini-SRC register-class
// ALU instruction (fetch T0..T2, execute T3..T6). Emits register/bus strobes and
// ALU_Control for the datapath and reads the IR back for decode in T3.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start, all outputs low
// T0     | PC onto bus, load MAR, Z <= PC + 1
// T1     | Z low onto PC, memory read into MDR
// T2     | MDR onto bus, load IR
// T3     | decode live ir; first operand step, or straight to DONE if illegal
// T4     | unary: write Ra; binary/wide: second operand into ALU
// T5     | binary: write Ra; wide: Z low into LO
// T6     | wide: Z high into HI
// DONE   | one-cycle done pulse, illegal valid
module alu_step_sequencer #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] ALU_OPS   = 32'h0001_FFF8,
  parameter logic [31:0] UNARY_OPS = 32'h0000_6000,
  parameter logic [31:0] WIDE_OPS  = 32'h0001_8000
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic [4:0]          alu_ctrl
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  typedef enum logic [1:0] {CL_UNARY, CL_BINARY, CL_WIDE} cls_t;

  localparam logic [4:0] NR = 5'(NUM_REGS);

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d;
  logic [4:0] op_q, op_d;
  logic [3:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic       illegal_q, illegal_d;

  logic [4:0] op_live;
  logic [3:0] ra_live, rb_live, rc_live;
  cls_t       cls_live;
  logic       ill_live;

  // Low IR bits carry immediates/unused fields for this instruction class.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[14:0];

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Live decode of the IR; only consulted while in T3.
  always_comb begin
    op_live = ir[31:27];
    ra_live = ir[26:23];
    rb_live = ir[22:19];
    rc_live = ir[18:15];
    if (WIDE_OPS[op_live])       cls_live = CL_WIDE;
    else if (UNARY_OPS[op_live]) cls_live = CL_UNARY;
    else                         cls_live = CL_BINARY;
    ill_live = !ALU_OPS[op_live]
             || ({1'b0, ra_live} >= NR)
             || ({1'b0, rb_live} >= NR)
             || ((cls_live == CL_BINARY) && ({1'b0, rc_live} >= NR));
  end

  // Next-state, field capture on the T3 exit, and illegal update on DONE entry.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    op_d      = op_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rc_d      = rc_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        cls_d = cls_live;
        op_d  = op_live;
        ra_d  = ra_live;
        rb_d  = rb_live;
        rc_d  = rc_live;
        state_d = ill_live ? S_DONE : S_T4;
      end
      S_T4:   state_d = (cls_q == CL_UNARY) ? S_DONE : S_T5;
      S_T5:   state_d = (cls_q == CL_WIDE) ? S_T6 : S_DONE;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = start ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Legal paths reach DONE only from T4..T6, so only the T3 exit can flag.
    if (state_d == S_DONE && state_q != S_DONE) begin
      illegal_d = (state_q == S_T3) ? ill_live : 1'b0;
    end
  end

  // State and captured-field registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cls_q     <= CL_BINARY;
      op_q      <= 5'd0;
      ra_q      <= 4'd0;
      rb_q      <= 4'd0;
      rc_q      <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode from the registered state and captured fields.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    illegal  = illegal_q;
    Rin      = '0;
    Rout     = '0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    alu_ctrl = 5'd0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (!ill_live) begin
          case (cls_live)
            CL_UNARY: begin
              Rout     = onehot(rb_live);
              Zin      = 1'b1;
              alu_ctrl = op_live;
            end
            CL_WIDE: begin
              Rout = onehot(ra_live);
              Yin  = 1'b1;
            end
            default: begin
              Rout = onehot(rb_live);
              Yin  = 1'b1;
            end
          endcase
        end
      end
      S_T4: begin
        case (cls_q)
          CL_UNARY: begin
            Zlowout = 1'b1;
            Rin     = onehot(ra_q);
          end
          CL_WIDE: begin
            Rout     = onehot(rb_q);
            Zin      = 1'b1;
            alu_ctrl = op_q;
          end
          default: begin
            Rout     = onehot(rc_q);
            Zin      = 1'b1;
            alu_ctrl = op_q;
          end
        endcase
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls_q == CL_WIDE) LOin = 1'b1;
        else                  Rin  = onehot(ra_q);
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_step_sequencer.sv
`timescale 1ns/1ps
// Directed bench: a small behavioural Mini-SRC datapath follows the sequencer's
// strobes so register/HI/LO results can be compared with hand-computed values.
module tb_alu_step_sequencer;

  localparam logic [13:0] PCOUT  = 14'h2000, MARIN  = 14'h1000, INCPC = 14'h0800,
                          ZIN    = 14'h0400, ZLO    = 14'h0200, ZHI   = 14'h0100,
                          PCIN   = 14'h0080, READ   = 14'h0040, MDRIN = 14'h0020,
                          MDROUT = 14'h0010, IRIN   = 14'h0008, YIN   = 14'h0004,
                          HIIN   = 14'h0002, LOIN   = 14'h0001;

  logic clock = 1'b0;
  logic clear, start, start8;
  logic [31:0] ir8;
  always #5 clock = ~clock;

  // main DUT (NUM_REGS = 16)
  logic busy, done, illegal, PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_ctrl;
  logic [31:0] IR;

  alu_step_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .ir(IR),
    .busy(busy), .done(done), .illegal(illegal), .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .alu_ctrl(alu_ctrl)
  );

  // second DUT with NUM_REGS = 8, ir driven directly
  logic busy8, done8, illegal8, PCout8, MARin8, IncPC8, Zin8, Zlowout8, Zhighout8;
  logic PCin8, Read8, MDRin8, MDRout8, IRin8, Yin8, HIin8, LOin8;
  logic [7:0] Rin8, Rout8;
  logic [4:0] alu_ctrl8;

  alu_step_sequencer #(.NUM_REGS(8)) dut8 (
    .clock(clock), .clear(clear), .start(start8), .ir(ir8),
    .busy(busy8), .done(done8), .illegal(illegal8), .Rin(Rin8), .Rout(Rout8),
    .PCout(PCout8), .MARin(MARin8), .IncPC(IncPC8), .Zin(Zin8), .Zlowout(Zlowout8),
    .Zhighout(Zhighout8), .PCin(PCin8), .Read(Read8), .MDRin(MDRin8), .MDRout(MDRout8),
    .IRin(IRin8), .Yin(Yin8), .HIin(HIin8), .LOin(LOin8), .alu_ctrl(alu_ctrl8)
  );

  wire [13:0] strb  = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
                       MDRin, MDRout, IRin, Yin, HIin, LOin};
  wire [13:0] strb8 = {PCout8, MARin8, IncPC8, Zin8, Zlowout8, Zhighout8, PCin8, Read8,
                       MDRin8, MDRout8, IRin8, Yin8, HIin8, LOin8};
  wire [53:0] obs   = {busy, done, illegal, alu_ctrl, strb, Rin, Rout};
  wire [37:0] obs8  = {busy8, done8, illegal8, alu_ctrl8, strb8, Rin8, Rout8};

  // behavioural datapath
  logic [31:0] R [16];
  logic [31:0] Y, HI, LO, PC, MAR, MDR, bus, instr_word;
  logic [63:0] Z, alu_res;
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  always_comb begin
    bus = 32'd0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus = R[i];
    if (Zlowout)  bus = Z[31:0];
    if (Zhighout) bus = Z[63:32];
    if (MDRout)   bus = MDR;
    if (PCout)    bus = PC;
  end

  always_comb begin
    alu_res = 64'd0;
    if (IncPC) alu_res = {32'd0, bus + 32'd1};
    else begin
      case (alu_ctrl)
        5'd3:  alu_res = {32'd0, Y + bus};
        5'd4:  alu_res = {32'd0, Y - bus};
        5'd14: alu_res = {32'd0, 32'd0 - bus};
        5'd15: alu_res = {32'd0, Y} * {32'd0, bus};
        default: alu_res = 64'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (pl_en) R[pl_idx] <= pl_val;
    for (int i = 0; i < 16; i++) if (Rin[i]) R[i] <= bus;
    if (Yin)   Y   <= bus;
    if (Zin)   Z   <= alu_res;
    if (HIin)  HI  <= bus;
    if (LOin)  LO  <= bus;
    if (IRin)  IR  <= bus;
    if (MARin) MAR <= bus;
    if (PCin)  PC  <= bus;
    if (Read && MDRin) MDR <= instr_word;
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [53:0] mk(input logic b, input logic d, input logic il,
                                     input logic [4:0] alu, input logic [13:0] s,
                                     input logic [15:0] ri, input logic [15:0] ro);
    return {b, d, il, alu, s, ri, ro};
  endfunction

  function automatic logic [37:0] mk8(input logic b, input logic d, input logic il,
                                      input logic [4:0] alu, input logic [13:0] s,
                                      input logic [7:0] ri, input logic [7:0] ro);
    return {b, d, il, alu, s, ri, ro};
  endfunction

  function automatic logic [15:0] oh(input int i);
    return 16'd1 << i;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [53:0] e);
    @(posedge clock); #1;
    chk(tag, {10'd0, obs}, {10'd0, e});
  endtask

  task automatic step8(input string tag, input logic [37:0] e);
    @(posedge clock); #1;
    chk(tag, {26'd0, obs8}, {26'd0, e});
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  // T0..T2; start is dropped after T0 unless hold is set
  task automatic fetch(input string tag, input logic il, input logic hold);
    step({tag, "_t0"}, mk(1, 0, il, 0, PCOUT | MARIN | INCPC | ZIN, 0, 0));
    if (!hold) start = 1'b0;
    step({tag, "_t1"}, mk(1, 0, il, 0, ZLO | PCIN | READ | MDRIN, 0, 0));
    step({tag, "_t2"}, mk(1, 0, il, 0, MDROUT | IRIN, 0, 0));
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; start8 = 1'b0; ir8 = 32'd0;
    pl_en = 1'b0; pl_idx = 4'd0; pl_val = 32'd0; instr_word = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset", {10'd0, obs}, 64'd0);
    chk("reset8", {26'd0, obs8}, 64'd0);
    clear = 1'b0;

    // neg R4, R7 with start held across DONE
    preload(4'd7, 32'h0000_0034);
    preload(4'd4, 32'h0000_0011);
    instr_word = 32'h7238_0000;
    start = 1'b1;
    fetch("neg", 1'b0, 1'b1);
    step("neg_t3", mk(1, 0, 0, 5'b01110, ZIN, 0, oh(7)));
    step("neg_t4", mk(1, 0, 0, 0, ZLO, oh(4), 0));
    step("neg_done", mk(1, 1, 0, 0, 0, 0, 0));
    chk("neg_r4", {32'd0, R[4]}, 64'hFFFF_FFCC);

    // back-to-back: T0 directly after DONE, then clear during T4
    fetch("b2b", 1'b0, 1'b0);
    step("b2b_t3", mk(1, 0, 0, 5'b01110, ZIN, 0, oh(7)));
    step("b2b_t4", mk(1, 0, 0, 0, ZLO, oh(4), 0));
    clear = 1'b1;
    step("clear_idle", 54'd0);
    clear = 1'b0;
    chk("clear_r4", {32'd0, R[4]}, 64'hFFFF_FFCC);
    step("clear_stays_idle", 54'd0);

    // add R5, R2, R4
    preload(4'd2, 32'h0000_0010);
    preload(4'd4, 32'h0000_0025);
    preload(4'd5, 32'hDEAD_BEEF);
    instr_word = 32'h1A92_0000;
    start = 1'b1;
    fetch("add", 1'b0, 1'b0);
    step("add_t3", mk(1, 0, 0, 0, YIN, 0, oh(2)));
    step("add_t4", mk(1, 0, 0, 5'd3, ZIN, 0, oh(4)));
    step("add_t5", mk(1, 0, 0, 0, ZLO, oh(5), 0));
    step("add_done", mk(1, 1, 0, 0, 0, 0, 0));
    step("add_idle", 54'd0);
    chk("add_r5", {32'd0, R[5]}, 64'h0000_0035);

    // mul R3, R1
    preload(4'd3, 32'h0001_0000);
    preload(4'd1, 32'h0003_0000);
    instr_word = 32'h7988_0000;
    start = 1'b1;
    fetch("mul", 1'b0, 1'b0);
    step("mul_t3", mk(1, 0, 0, 0, YIN, 0, oh(3)));
    step("mul_t4", mk(1, 0, 0, 5'd15, ZIN, 0, oh(1)));
    step("mul_t5", mk(1, 0, 0, 0, ZLO | LOIN, 0, 0));
    step("mul_t6", mk(1, 0, 0, 0, ZHI | HIIN, 0, 0));
    step("mul_done", mk(1, 1, 0, 0, 0, 0, 0));
    step("mul_idle", 54'd0);
    chk("mul_lo", {32'd0, LO}, 64'h0000_0000);
    chk("mul_hi", {32'd0, HI}, 64'h0000_0003);

    // illegal opcode 0: DONE right after T3, illegal held afterwards
    instr_word = 32'h0000_0000;
    start = 1'b1;
    fetch("ill", 1'b0, 1'b0);
    step("ill_t3", mk(1, 0, 0, 0, 0, 0, 0));
    step("ill_done", mk(1, 1, 1, 0, 0, 0, 0));
    step("ill_idle_hold", mk(0, 0, 1, 0, 0, 0, 0));

    // NUM_REGS = 8: Ra=4, Rb=7 legal
    ir8 = 32'h7238_0000;
    start8 = 1'b1;
    step8("n8_t0", mk8(1, 0, 0, 0, PCOUT | MARIN | INCPC | ZIN, 0, 0));
    start8 = 1'b0;
    repeat (2) @(posedge clock);
    step8("n8_legal_t3", mk8(1, 0, 0, 5'd14, ZIN, 0, 8'h80));
    step8("n8_legal_t4", mk8(1, 0, 0, 0, ZLO, 8'h10, 0));
    step8("n8_legal_done", mk8(1, 1, 0, 0, 0, 0, 0));
    step8("n8_idle", mk8(0, 0, 0, 0, 0, 0, 0));

    // NUM_REGS = 8: Rb=9 illegal
    ir8 = 32'h7248_0000;
    start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clock);
    step8("n8_rb9_t3", mk8(1, 0, 0, 0, 0, 0, 0));
    step8("n8_rb9_done", mk8(1, 1, 1, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_step_sequencer.md
# alu_step_sequencer

Parametrised control-step sequencer that drives the Mini-SRC datapath through one complete fetch/execute of a register-class ALU instruction. It replaces hand-written per-instruction T0..T5 control stimulus. It sits beside `datapath`: it emits the one-hot register enables, bus-select strobes and ALU_Control, and reads back the IR contents. It covers unary ops (neg/not), binary ops (add/sub/and/or/shifts) and wide ops (mul/div, results to HI/LO) under one state machine.

## Interface
Parameters:
- NUM_REGS, 16, number of general registers driven (8..16); width of Rin/Rout.
- ALU_OPS, 32'h0001_FFF8, bit k set = opcode k is a legal ALU instruction.
- UNARY_OPS, 32'h0000_6000, bit k set = opcode k is unary (Ra <- op Rb); defaults are not=13, neg=14.
- WIDE_OPS, 32'h0001_8000, bit k set = opcode k writes HI/LO (Ra, Rb sources); defaults are mul=15, div=16.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, synchronous, active-high.
- start  in  1  request one instruction cycle; sampled in IDLE or DONE.
- ir  in  32  datapath IR contents; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- illegal  out  1  valid with done; opcode not in ALU_OPS, or a register index >= NUM_REGS.
- Rin, Rout  out  NUM_REGS  one-hot general-register load and drive enables.
- PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- alu_ctrl  out  5  ALU_Control; equals the opcode during the ALU step, otherwise 0.

## Operation
- Moore FSM: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE. All outputs decode from the registered state and the captured fields.
- T0: PCout, MARin, IncPC, Zin. T1: Zlowout, PCin, Read, MDRin. T2: MDRout, IRin.
- T3 decodes the live ir. Opcode, Ra, Rb and Rc are captured on the edge leaving T3 and used in T4..T6.
- Unary ops:
  - T3: Rout[Rb], Zin, alu_ctrl = op.
  - T4: Zlowout, Rin[Ra].
  - Then DONE.
- Binary ops:
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], Zin, alu_ctrl = op.
  - T5: Zlowout, Rin[Ra].
  - Then DONE.
- Wide ops:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], Zin, alu_ctrl = op.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then DONE.
- Illegal (decided in T3):
  - No strobes are asserted in T3.
  - Next state is DONE with illegal = 1.
  - No register, HI or LO write occurs.
- Classification precedence is WIDE_OPS, then UNARY_OPS, then binary, for any opcode present in ALU_OPS.
- Only the register fields used by the class are range-checked against NUM_REGS.
- At most one Rin bit and one Rout bit are high in any cycle.
- Rin and Rout are never high in the same cycle.

## Timing
- After clear: state IDLE; every output 0, including busy, done and illegal.
- start high in IDLE at edge k: T0 is active in cycle k+1.
- busy duration from T0 through DONE inclusive:
  - unary 6 cycles;
  - binary 7 cycles;
  - wide 8 cycles;
  - illegal 5 cycles.
- DONE lasts exactly one cycle. If start is high in DONE, the next state is T0 (back-to-back, no IDLE gap). Otherwise the next state is IDLE.
- start while in T0..T6 is ignored. It is not queued.
- ir must be stable during T3. The datapath loads IR on the edge ending T2.
- clear mid-operation: the next state is IDLE and all outputs are 0 in the following cycle. Captured fields are don't-care. No partial write follows.
- illegal holds its value until the next DONE or clear. It is only meaningful while done is high.

## Test plan
- neg R4, R7:
  - Stimulus: preload R7 = 0x34, start, ir = 0x72380000.
  - T3 shows Rout[7], Zin, alu_ctrl = 5'b01110.
  - T4 shows Zlowout, Rin[4].
  - Required result: R4 = 0xFFFFFFCC, done at cycle 6 of busy, illegal = 0.
- add R5, R2, R4:
  - Stimulus: R2 = 0x10, R4 = 0x25, ir = 0x1A920000.
  - Yin with Rout[2] in T3; Zin with Rout[4] in T4; Rin[5] in T5.
  - Required result: R5 = 0x35, busy for 7 cycles.
- mul R3, R1:
  - Stimulus: R3 = 0x00010000, R1 = 0x00030000, ir = 0x79880000.
  - LOin in T5, HIin in T6.
  - Required result: LO = 0x00000000, HI = 0x00000003, no Rin pulse, busy for 8 cycles.
- illegal opcode 0:
  - Stimulus: ir = 0x00000000.
  - Required response: DONE in the cycle after T3, done = illegal = 1, no Rin/HIin/LOin pulse.
  - With NUM_REGS = 8, ir = 0x72380000 (Ra = 4, Rb = 7) is legal.
  - With NUM_REGS = 8, an ir using Rb = 9 must raise illegal.
- back-to-back and clear:
  - Stimulus: hold start high across the neg instruction; T0 must follow DONE directly.
  - Second instruction: assert clear during its T4. Next cycle: IDLE, all outputs 0, R4 unchanged from its pre-T4 value.
